usb_tx_timer_serializer: RTL
============================

# usb_tx_timer_serializer

Transmit-side bit timing and serialization for the USB data path; the mirror of the receive timer and shifter. Accepts bytes over a one-cycle valid/ready strobe and emits a full-speed packet on d_plus/d_minus: SYNC, NRZI-encoded data LSB-first with bit stuffing, then EOP. Each bit lasts CLKS_PER_BIT system clocks, matching the receiver's 8-clock bit period. Sits between the TX packet FSM/FIFO and the bus drivers.

## Interface
- CLKS_PER_BIT, 8, system clocks per USB bit period (>=2)
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- tx_start  in  1  begin a packet; sampled in IDLE only
- tx_data  in  8  next byte, LSB sent first
- tx_data_valid  in  1  tx_data holds a byte; sampled only when tx_data_ready=1
- tx_data_ready  out  1  one-cycle pulse: byte is taken this cycle if tx_data_valid=1
- d_plus  out  1  bus D+ (registered)
- d_minus  out  1  bus D- (registered)
- transmitting  out  1  high while a packet is on the bus
- tx_done  out  1  one-cycle pulse on the final clock of EOP

## Operation
- States: IDLE, SYNC, DATA, EOP_SE0, EOP_J.
- Line states: J = (d_plus=1, d_minus=0); K = (0,1); SE0 = (0,0). IDLE drives J.
- Bit counter 0..CLKS_PER_BIT-1, cleared in IDLE. The line changes only when the counter wraps to 0. The bit strobe is the cycle with counter = CLKS_PER_BIT-1.
- NRZI: a 0 bit toggles J/K; a 1 bit holds the previous level.
- IDLE: tx_start=1 → SYNC. Other inputs are ignored.
- SYNC: 8 bits 0000_0001 (LSB-first, i.e. 0x80), giving K J K J K J K K.
- tx_data_ready pulses on the bit strobe of the last period before the next data bit: the last SYNC bit, the 8th bit of a byte, or a stuff bit that follows the 8th bit.
  - tx_data_valid=1 at the pulse: the byte loads and DATA continues.
  - tx_data_valid=0 at the pulse: go to EOP_SE0. A zero-byte packet is legal.
- Stuffing: a ones counter (0..6) counts consecutive transmitted 1s, starting with the SYNC final 1. It resets on every 0, including stuff bits.
  - When it reaches 6, the next bit period carries a stuffed 0 (toggle).
  - During a stuff period the shift register holds and the bit index does not advance.
  - A stuff bit after the last data bit is sent before EOP.
- EOP_SE0 lasts 2 bit periods, then EOP_J lasts 1 bit period, then IDLE.
- tx_start outside IDLE is ignored.

## Timing
- Reset (async, immediate): d_plus=1, d_minus=0, tx_data_ready=0, transmitting=0, tx_done=0, state IDLE, all counters 0.
- tx_start accepted at cycle t:
  - the first SYNC bit appears at t+1;
  - transmitting=1 from t+1;
  - every bit, including stuff and EOP bits, is held exactly CLKS_PER_BIT cycles.
- tx_done=1 on the final clock of EOP_J. transmitting=0 and the state is IDLE from the next cycle; a new tx_start is accepted on that cycle.
- Packet length is (8 + 8·N + S + 3)·CLKS_PER_BIT clocks for N bytes and S stuff bits.
- Reset mid-packet aborts the packet: the line returns to J with no EOP, and tx_done is not pulsed.

## Configuration
- TX_BIT_STUFF_EN defined: stuffing as specified above.
- TX_BIT_STUFF_EN undefined:
  - the ones counter and stuff logic are removed;
  - bytes are always 8 bit periods;
  - tx_data_ready always pulses on the strobe of the 8th bit.
  - This build is for bring-up and is not USB-compliant.

## Test plan
- Reset with n_rst=0 for 3 cycles, then release → d_plus=1, d_minus=0, tx_data_ready=0, transmitting=0, tx_done=0.
- Zero-byte packet (CLKS_PER_BIT=8): tx_start at t, tx_data_valid=0 → K J K J K J K K, then SE0 for t+65..t+80, J for t+81..t+88; tx_done at t+88.
- Single byte 0x00: line after SYNC is J K J K J K J K, then EOP; tx_done at t+152; exactly one tx_data_ready pulse is accepted (at t+64).
- Byte 0xFF with TX_BIT_STUFF_EN: a stuff toggle follows the 5th data bit; the second ready pulse comes at t+136, not t+128; tx_done at t+160.
- Byte 0xFF without TX_BIT_STUFF_EN: no toggle within the byte; ready at t+128; tx_done at t+152.
- Back-to-back 0xA5, 0x3C: ready pulses at t+64, t+128 and t+192 (valid=0 at t+192 ends the packet). Apply tx_start mid-packet → ignored. Apply n_rst low at t+100 → immediate J, transmitting=0, no tx_done.

Source files
------------

// File: rtl/usb_tx_if.sv
// usb_tx_if: byte handshake from the TX packet logic plus the serializer's bus-line outputs.
interface usb_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic       d_plus;
    logic       d_minus;
    logic       transmitting;
    logic       tx_done;
    modport master (
        output tx_start, tx_data, tx_data_valid,
        input  tx_data_ready, d_plus, d_minus, transmitting, tx_done
    );
    modport slave (
        input  tx_start, tx_data, tx_data_valid,
        output tx_data_ready, d_plus, d_minus, transmitting, tx_done
    );
endinterface

// File: rtl/usb_tx_timer_serializer.sv
// usb_tx_timer_serializer: full-speed USB TX bit timer, NRZI encoder and serializer (SYNC, data, EOP).
// Bit stuffing is compiled in only when TX_BIT_STUFF_EN is defined.
module usb_tx_timer_serializer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic    clk,
    input  logic    n_rst,
    usb_tx_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;
    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [7:0]      r_shift, w_shift;
    logic [2:0]      r_idx, w_idx;
    logic            r_stuff, w_stuff;
    logic            r_dp, w_dp;
    logic            r_dm, w_dm;
    logic            w_strobe, w_ser, w_need_stuff, w_boundary;
`ifdef TX_BIT_STUFF_EN
    logic [2:0]      r_ones, w_ones_nxt;
    // r_ones counts consecutive 1s sent before the current period; a stuff bit counts as a 0
    assign w_ones_nxt   = (!r_stuff && r_shift[0]) ? r_ones + 3'd1 : 3'd0;
    assign w_need_stuff = w_ones_nxt == 3'd6;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst)
            r_ones <= 3'd0;
        else if (r_state == IDLE)
            r_ones <= 3'd0;
        else if (w_strobe && w_ser)
            r_ones <= w_ones_nxt;
`else
    assign w_need_stuff = 1'b0;
`endif
    assign w_strobe   = r_cnt == CW'(CLKS_PER_BIT - 1);
    assign w_ser      = r_state == SYNC || r_state == DATA;
    // A stuff period keeps the index of the bit it follows, so idx 7 also covers a trailing stuff bit
    assign w_boundary = r_idx == 3'd7 && !w_need_stuff;
    assign bus.tx_data_ready = w_strobe && w_ser && w_boundary;
    assign bus.tx_done       = w_strobe && r_state == EOP_J;
    assign bus.transmitting  = r_state != IDLE;
    assign bus.d_plus        = r_dp;
    assign bus.d_minus       = r_dm;
    always_comb begin
        w_state = r_state;
        w_cnt   = (r_state == IDLE || w_strobe) ? '0 : r_cnt + CW'(1);
        w_shift = r_shift;
        w_idx   = r_idx;
        w_stuff = r_stuff;
        w_dp    = r_dp;
        w_dm    = r_dm;
        if (r_state == IDLE) begin
            if (bus.tx_start) begin
                w_state = SYNC;
                w_shift = 8'h80;
                w_idx   = 3'd0;
                w_stuff = 1'b0;
                w_dp    = 1'b0;
                w_dm    = 1'b1;
            end
        end else if (w_strobe) begin
            if (w_ser) begin
                if (w_boundary) begin
                    w_idx   = 3'd0;
                    w_stuff = 1'b0;
                    if (bus.tx_data_valid) begin
                        w_state = DATA;
                        w_shift = bus.tx_data;
                        w_dp    = bus.tx_data[0] ? r_dp : ~r_dp;
                        w_dm    = ~w_dp;
                    end else begin
                        w_state = EOP_SE0;
                        w_dp    = 1'b0;
                        w_dm    = 1'b0;
                    end
                end else if (w_need_stuff) begin
                    w_stuff = 1'b1;
                    w_dp    = ~r_dp;
                    w_dm    = r_dp;
                end else begin
                    w_stuff = 1'b0;
                    w_shift = r_shift >> 1;
                    w_idx   = r_idx + 3'd1;
                    w_dp    = r_shift[1] ? r_dp : ~r_dp;
                    w_dm    = ~w_dp;
                end
            end else if (r_state == EOP_SE0) begin
                w_idx = r_idx + 3'd1;
                if (r_idx[0]) begin
                    w_state = EOP_J;
                    w_dp    = 1'b1;
                    w_dm    = 1'b0;
                end
            end else begin
                w_state = IDLE;
                w_idx   = 3'd0;
            end
        end
    end
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= 8'd0;
            r_idx   <= 3'd0;
            r_stuff <= 1'b0;
            r_dp    <= 1'b1;
            r_dm    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_shift <= w_shift;
            r_idx   <= w_idx;
            r_stuff <= w_stuff;
            r_dp    <= w_dp;
            r_dm    <= w_dm;
        end
endmodule
